// File: rtl/id_ex_operand_stage_if.sv
// Decode-to-execute operand stage bundle: decode slot, MEM/WB bypass sources,
// flush/stall control in; registered EX fields and load-use stall out.
interface id_ex_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            i_flush;
    logic            i_stall;
    logic            i_id_valid;
    logic [PC_W-1:0] i_id_pc;
    logic [4:0]      i_rs1_addr;
    logic [4:0]      i_rs2_addr;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic [4:0]      i_rd_addr;
    logic            i_rd_wren;
    logic            i_is_load;
    logic [4:0]      i_mem_rd_addr;
    logic            i_mem_wren;
    logic [XLEN-1:0] i_mem_data;
    logic [4:0]      i_wb_rd_addr;
    logic            i_wb_wren;
    logic [XLEN-1:0] i_wb_data;

    logic            o_load_use_stall;
    logic            o_ex_valid;
    logic [PC_W-1:0] o_ex_pc;
    logic [4:0]      o_ex_rd_addr;
    logic            o_ex_wren;
    logic            o_ex_is_load;
    logic [XLEN-1:0] o_ex_rs1_data;
    logic [XLEN-1:0] o_ex_rs2_data;
    logic            o_ex_rs1_fwd;
    logic            o_ex_rs2_fwd;

    modport master (
        output i_flush, i_stall, i_id_valid, i_id_pc, i_rs1_addr, i_rs2_addr,
               i_rs1_data, i_rs2_data, i_rd_addr, i_rd_wren, i_is_load,
               i_mem_rd_addr, i_mem_wren, i_mem_data,
               i_wb_rd_addr, i_wb_wren, i_wb_data,
        input  o_load_use_stall, o_ex_valid, o_ex_pc, o_ex_rd_addr, o_ex_wren,
               o_ex_is_load, o_ex_rs1_data, o_ex_rs2_data, o_ex_rs1_fwd, o_ex_rs2_fwd
    );

    modport slave (
        input  i_flush, i_stall, i_id_valid, i_id_pc, i_rs1_addr, i_rs2_addr,
               i_rs1_data, i_rs2_data, i_rd_addr, i_rd_wren, i_is_load,
               i_mem_rd_addr, i_mem_wren, i_mem_data,
               i_wb_rd_addr, i_wb_wren, i_wb_data,
        output o_load_use_stall, o_ex_valid, o_ex_pc, o_ex_rd_addr, o_ex_wren,
               o_ex_is_load, o_ex_rs1_data, o_ex_rs2_data, o_ex_rs1_fwd, o_ex_rs2_fwd
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand bypass (EX/MEM/WB) and load-use bubbles.
// Optional load-use stall counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic i_clk,
    input  logic rst_n,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0] o_stall_cnt,
`endif
    id_ex_operand_stage_if.slave bus
);

    typedef struct packed {
        logic            fwd;
        logic [XLEN-1:0] data;
    } operand_t;

    // Priority x0 > EX producer > MEM > WB > register file.
    function automatic operand_t resolve(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_en,
        input logic [4:0]      ex_rd,
        input logic            mem_wren,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_wren,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        operand_t r;
        r = '0;
        if (addr == 5'd0) begin
            r = '0;
        end else if (ex_en && (ex_rd == addr)) begin
            r.fwd = 1'b1;
        end else if (mem_wren && (mem_rd == addr)) begin
            r.data = mem_data;
        end else if (wb_wren && (wb_rd == addr)) begin
            r.data = wb_data;
        end else begin
            r.data = rf_data;
        end
        return r;
    endfunction

    logic            ex_valid_q,    ex_valid_d;
    logic [PC_W-1:0] ex_pc_q,       ex_pc_d;
    logic [4:0]      ex_rd_addr_q,  ex_rd_addr_d;
    logic            ex_wren_q,     ex_wren_d;
    logic            ex_is_load_q,  ex_is_load_d;
    logic [XLEN-1:0] ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
    logic            ex_rs1_fwd_q,  ex_rs1_fwd_d;
    logic            ex_rs2_fwd_q,  ex_rs2_fwd_d;

    logic     ex_fwd_en;
    logic     load_use;
    operand_t rs1_res;
    operand_t rs2_res;

    assign ex_fwd_en = ex_valid_q && ex_wren_q;

    always_comb begin
        rs1_res = resolve(bus.i_rs1_addr, bus.i_rs1_data, ex_fwd_en, ex_rd_addr_q,
                          bus.i_mem_wren, bus.i_mem_rd_addr, bus.i_mem_data,
                          bus.i_wb_wren, bus.i_wb_rd_addr, bus.i_wb_data);
        rs2_res = resolve(bus.i_rs2_addr, bus.i_rs2_data, ex_fwd_en, ex_rd_addr_q,
                          bus.i_mem_wren, bus.i_mem_rd_addr, bus.i_mem_data,
                          bus.i_wb_wren, bus.i_wb_rd_addr, bus.i_wb_data);
    end

    // A load in EX cannot be forwarded; its data is available from MEM one cycle later.
    always_comb begin
        load_use = bus.i_id_valid && ex_valid_q && ex_is_load_q && ex_wren_q &&
                   (ex_rd_addr_q != 5'd0) &&
                   ((ex_rd_addr_q == bus.i_rs1_addr) || (ex_rd_addr_q == bus.i_rs2_addr));
    end

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_rd_addr_d  = ex_rd_addr_q;
        ex_wren_d     = ex_wren_q;
        ex_is_load_d  = ex_is_load_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_rs1_fwd_d  = ex_rs1_fwd_q;
        ex_rs2_fwd_d  = ex_rs2_fwd_q;
        if (bus.i_flush || (!bus.i_stall && load_use)) begin
            ex_valid_d    = 1'b0;
            ex_pc_d       = '0;
            ex_rd_addr_d  = '0;
            ex_wren_d     = 1'b0;
            ex_is_load_d  = 1'b0;
            ex_rs1_data_d = '0;
            ex_rs2_data_d = '0;
            ex_rs1_fwd_d  = 1'b0;
            ex_rs2_fwd_d  = 1'b0;
        end else if (!bus.i_stall) begin
            ex_valid_d    = bus.i_id_valid;
            ex_pc_d       = bus.i_id_pc;
            ex_rd_addr_d  = bus.i_rd_addr;
            ex_wren_d     = bus.i_id_valid && bus.i_rd_wren;
            ex_is_load_d  = bus.i_id_valid && bus.i_is_load;
            ex_rs1_data_d = rs1_res.data;
            ex_rs2_data_d = rs2_res.data;
            ex_rs1_fwd_d  = rs1_res.fwd;
            ex_rs2_fwd_d  = rs2_res.fwd;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rd_addr_q  <= '0;
            ex_wren_q     <= 1'b0;
            ex_is_load_q  <= 1'b0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_rs1_fwd_q  <= 1'b0;
            ex_rs2_fwd_q  <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rd_addr_q  <= ex_rd_addr_d;
            ex_wren_q     <= ex_wren_d;
            ex_is_load_q  <= ex_is_load_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_rs1_fwd_q  <= ex_rs1_fwd_d;
            ex_rs2_fwd_q  <= ex_rs2_fwd_d;
        end
    end

    assign bus.o_load_use_stall = load_use;
    assign bus.o_ex_valid       = ex_valid_q;
    assign bus.o_ex_pc          = ex_pc_q;
    assign bus.o_ex_rd_addr     = ex_rd_addr_q;
    assign bus.o_ex_wren        = ex_wren_q;
    assign bus.o_ex_is_load     = ex_is_load_q;
    assign bus.o_ex_rs1_data    = ex_rs1_data_q;
    assign bus.o_ex_rs2_data    = ex_rs2_data_q;
    assign bus.o_ex_rs1_fwd     = ex_rs1_fwd_q;
    assign bus.o_ex_rs2_fwd     = ex_rs2_fwd_q;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count only bubbles actually inserted; saturate instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_use && !bus.i_stall && !bus.i_flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed test-plan steps followed
// by randomized traffic against a reference model of the ID/EX operand rules.
module tb_id_ex_operand_stage;
    localparam int XLEN = 32;
    localparam int PC_W = 32;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wren;
        logic        is_load;
        logic        f1;
        logic        f2;
        logic [31:0] d1;
        logic [31:0] d2;
    } ex_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    id_ex_operand_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .i_clk       (clk),
        .rst_n       (rst_n),
`ifdef ID_EX_STALL_CNT_EN
        .o_stall_cnt (stall_cnt),
`endif
        .bus         (bus)
    );

    ex_t obs;
    assign obs = {bus.o_ex_valid, bus.o_ex_pc, bus.o_ex_rd_addr, bus.o_ex_wren,
                  bus.o_ex_is_load, bus.o_ex_rs1_fwd, bus.o_ex_rs2_fwd,
                  bus.o_ex_rs1_data, bus.o_ex_rs2_data};

    ex_t         exp_ex;
    logic [31:0] exp_cnt;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Architectural view: the newest in-flight writer of a register supplies its
    // value; a writer still in EX has no value yet, so EX must take it itself.
    function automatic logic [XLEN:0] model_operand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return '0;
        for (int k = 0; k < 3; k++) begin
            logic        en;
            logic [4:0]  rd;
            logic [31:0] v;
            logic        in_ex;
            case (k)
                0:       begin en = exp_ex.valid && exp_ex.wren; rd = exp_ex.rd; v = '0; in_ex = 1'b1; end
                1:       begin en = bus.i_mem_wren; rd = bus.i_mem_rd_addr; v = bus.i_mem_data; in_ex = 1'b0; end
                default: begin en = bus.i_wb_wren; rd = bus.i_wb_rd_addr; v = bus.i_wb_data; in_ex = 1'b0; end
            endcase
            if (en && rd == a) return {in_ex, v};
        end
        return {1'b0, rf};
    endfunction

    function automatic logic model_lu();
        return bus.i_id_valid && exp_ex.valid && exp_ex.is_load && exp_ex.wren &&
               exp_ex.rd != 5'd0 &&
               (exp_ex.rd == bus.i_rs1_addr || exp_ex.rd == bus.i_rs2_addr);
    endfunction

    function automatic ex_t model_next();
        ex_t n;
        n = exp_ex;
        if (bus.i_flush) n = '0;
        else if (bus.i_stall) n = exp_ex;
        else if (model_lu()) n = '0;
        else begin
            n.valid   = bus.i_id_valid;
            n.pc      = bus.i_id_pc;
            n.rd      = bus.i_rd_addr;
            n.wren    = bus.i_id_valid && bus.i_rd_wren;
            n.is_load = bus.i_id_valid && bus.i_is_load;
            {n.f1, n.d1} = model_operand(bus.i_rs1_addr, bus.i_rs1_data);
            {n.f2, n.d2} = model_operand(bus.i_rs2_addr, bus.i_rs2_data);
        end
        return n;
    endfunction

    task automatic stall_chk();
        #1;
        check("load_use_stall", 128'(bus.o_load_use_stall), 128'(model_lu()));
    endtask

    task automatic tick();
        ex_t         nxt;
        logic [31:0] nc;
        nxt = model_next();
        nc  = exp_cnt;
        if (model_lu() && !bus.i_stall && !bus.i_flush && exp_cnt != 32'hFFFF_FFFF) nc = exp_cnt + 1;
        @(posedge clk);
        #1;
        exp_ex  = nxt;
        exp_cnt = nc;
        check("ex_regs", 128'(obs), 128'(exp_ex));
`ifdef ID_EX_STALL_CNT_EN
        check("stall_cnt", 128'(stall_cnt), 128'(exp_cnt));
`endif
    endtask

    task automatic clear_inputs();
        bus.i_flush = 0; bus.i_stall = 0; bus.i_id_valid = 0; bus.i_id_pc = '0;
        bus.i_rs1_addr = '0; bus.i_rs2_addr = '0; bus.i_rs1_data = '0; bus.i_rs2_data = '0;
        bus.i_rd_addr = '0; bus.i_rd_wren = 0; bus.i_is_load = 0;
        bus.i_mem_rd_addr = '0; bus.i_mem_wren = 0; bus.i_mem_data = '0;
        bus.i_wb_rd_addr = '0; bus.i_wb_wren = 0; bus.i_wb_data = '0;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [4:0] rd, input logic wren, input logic ld);
        bus.i_id_valid = 1; bus.i_id_pc = pc;
        bus.i_rs1_addr = r1; bus.i_rs2_addr = r2; bus.i_rs1_data = d1; bus.i_rs2_data = d2;
        bus.i_rd_addr = rd; bus.i_rd_wren = wren; bus.i_is_load = ld;
    endtask

    task automatic clear_bypass();
        bus.i_mem_wren = 0; bus.i_mem_rd_addr = '0; bus.i_mem_data = '0;
        bus.i_wb_wren = 0; bus.i_wb_rd_addr = '0; bus.i_wb_data = '0;
    endtask

    initial begin
        clear_inputs();
        exp_ex  = '0;
        exp_cnt = '0;
        #2 rst_n = 0;
        #1;
        check("reset_regs", 128'(obs), 128'(0));
        check("reset_stall", 128'(bus.o_load_use_stall), 128'(0));
`ifdef ID_EX_STALL_CNT_EN
        check("reset_cnt", 128'(stall_cnt), 128'(0));
`endif
        @(negedge clk);
        rst_n = 1;

        // Plain register file read
        set_id(32'h100, 5'd5, 5'd6, 32'h11, 32'h22, 5'd1, 1, 0);
        stall_chk();
        tick();
        check("plain_rs1", 128'(bus.o_ex_rs1_data), 128'(32'h11));
        check("plain_rs2", 128'(bus.o_ex_rs2_data), 128'(32'h22));
        check("plain_vld_fwd", 128'({bus.o_ex_valid, bus.o_ex_rs1_fwd, bus.o_ex_rs2_fwd}), 128'(3'b100));

        // WB same-cycle bypass over stale register file data
        set_id(32'h104, 5'd5, 5'd6, 32'h11, 32'h22, 5'd2, 1, 0);
        bus.i_wb_wren = 1; bus.i_wb_rd_addr = 5'd5; bus.i_wb_data = 32'hAA;
        tick();
        check("wb_bypass", 128'(bus.o_ex_rs1_data), 128'(32'hAA));

        // MEM beats WB; this instruction also writes x0 from EX
        set_id(32'h108, 5'd5, 5'd6, 32'h11, 32'h22, 5'd0, 1, 0);
        bus.i_mem_wren = 1; bus.i_mem_rd_addr = 5'd5; bus.i_mem_data = 32'hBB;
        tick();
        check("mem_over_wb", 128'(bus.o_ex_rs1_data), 128'(32'hBB));

        // x0 never forwards (EX writes x0, WB writes x0)
        clear_bypass();
        bus.i_wb_wren = 1; bus.i_wb_rd_addr = 5'd0; bus.i_wb_data = 32'hFF;
        set_id(32'h10C, 5'd0, 5'd0, 32'h55, 32'h66, 5'd4, 1, 0);
        tick();
        check("x0_rs1", 128'({bus.o_ex_rs1_fwd, bus.o_ex_rs1_data}), 128'(0));
        check("x0_rs2", 128'({bus.o_ex_rs2_fwd, bus.o_ex_rs2_data}), 128'(0));

        // Load to x7, then a consumer of x7
        clear_bypass();
        set_id(32'h110, 5'd2, 5'd2, 32'h0, 32'h0, 5'd7, 1, 1);
        stall_chk();
        tick();
        set_id(32'h114, 5'd2, 5'd7, 32'h3, 32'h99, 5'd8, 1, 0);
        stall_chk();
        check("lu_assert", 128'(bus.o_load_use_stall), 128'(1));
        tick();
        check("lu_bubble", 128'({bus.o_ex_valid, bus.o_ex_wren}), 128'(0));
`ifdef ID_EX_STALL_CNT_EN
        check("lu_cnt", 128'(stall_cnt), 128'(1));
`endif
        bus.i_mem_wren = 1; bus.i_mem_rd_addr = 5'd7; bus.i_mem_data = 32'h1234;
        stall_chk();
        check("lu_release", 128'(bus.o_load_use_stall), 128'(0));
        tick();
        check("lu_mem_data", 128'({bus.o_ex_valid, bus.o_ex_rs2_fwd, bus.o_ex_rs2_data}),
              128'({1'b1, 1'b0, 32'h1234}));

        // Non-load producer in EX forwards without a stall
        clear_bypass();
        set_id(32'h118, 5'd1, 5'd1, 32'h0, 32'h0, 5'd3, 1, 0);
        tick();
        set_id(32'h11C, 5'd3, 5'd1, 32'h77, 32'h5, 5'd9, 1, 0);
        stall_chk();
        check("ex_fwd_nostall", 128'(bus.o_load_use_stall), 128'(0));
        tick();
        check("ex_fwd", 128'({bus.o_ex_rs1_fwd, bus.o_ex_rs1_data}), 128'({1'b1, 32'h0}));

        // External stall holds EX for three cycles
        bus.i_stall = 1;
        set_id(32'h120, 5'd4, 5'd5, 32'hDEAD, 32'hBEEF, 5'd10, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", 128'({bus.o_ex_pc, bus.o_ex_rd_addr, bus.o_ex_rs2_data}),
                  128'({32'h11C, 5'd9, 32'h5}));
        end

        // Flush wins over stall
        bus.i_flush = 1;
        tick();
        check("flush_bubble", 128'({bus.o_ex_valid, bus.o_ex_wren, bus.o_ex_is_load}), 128'(0));
        bus.i_flush = 0;
        bus.i_stall = 0;

        // Randomized traffic with narrow register indices to provoke matches
        for (int i = 0; i < 400; i++) begin
            bus.i_flush       = ($urandom_range(0, 15) == 0);
            bus.i_stall       = ($urandom_range(0, 7) == 0);
            bus.i_id_valid    = ($urandom_range(0, 7) != 0);
            bus.i_id_pc       = $urandom;
            bus.i_rs1_addr    = 5'($urandom_range(0, 7));
            bus.i_rs2_addr    = 5'($urandom_range(0, 7));
            bus.i_rs1_data    = $urandom;
            bus.i_rs2_data    = $urandom;
            bus.i_rd_addr     = 5'($urandom_range(0, 7));
            bus.i_rd_wren     = 1'($urandom);
            bus.i_is_load     = ($urandom_range(0, 2) == 0);
            bus.i_mem_rd_addr = 5'($urandom_range(0, 7));
            bus.i_mem_wren    = 1'($urandom);
            bus.i_mem_data    = $urandom;
            bus.i_wb_rd_addr  = 5'($urandom_range(0, 7));
            bus.i_wb_wren     = 1'($urandom);
            bus.i_wb_data     = $urandom;
            stall_chk();
            tick();
        end

        // Asynchronous reset in the middle of operation
        clear_inputs();
        set_id(32'h200, 5'd1, 5'd2, 32'h3, 32'h4, 5'd6, 1, 1);
        tick();
        check("pre_reset_valid", 128'(bus.o_ex_valid), 128'(1));
        #2 rst_n = 0;
        #1;
        exp_ex  = '0;
        exp_cnt = '0;
        check("mid_reset_regs", 128'(obs), 128'(exp_ex));
        check("mid_reset_stall", 128'(bus.o_load_use_stall), 128'(0));
`ifdef ID_EX_STALL_CNT_EN
        check("mid_reset_cnt", 128'(stall_cnt), 128'(exp_cnt));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Pipeline register between decode/register-read and execute in the 5-stage RV32 core.
- Consumes the combinational rs1/rs2 read data from the register file and resolves operands against in-flight MEM and WB writes, including the same-edge WB write-through that the register file does not provide.
- Detects load-use hazards and inserts bubbles.
- Registers the operands, destination and control into the EX stage, with stall and flush.

Parameters:
- XLEN, 32, operand/data width.
- PC_W, 32, program counter width.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  branch/exception flush; EX register becomes a bubble.
- i_stall  in  1  external stall (memory wait); EX register holds.
- i_id_valid  in  1  decode slot holds a real instruction.
- i_id_pc  in  PC_W  decode PC.
- i_rs1_addr, i_rs2_addr  in  5  source register indices, also driven to the register file.
- i_rs1_data, i_rs2_data  in  XLEN  register file read data.
- i_rd_addr  in  5  destination index.
- i_rd_wren  in  1  instruction writes rd.
- i_is_load  in  1  instruction is a load.
- i_mem_rd_addr, i_mem_wren, i_mem_data  in  5/1/XLEN  MEM-stage result, final value including load data.
- i_wb_rd_addr, i_wb_wren, i_wb_data  in  5/1/XLEN  WB write port, same signals as the register file write.
- o_load_use_stall  out  1  combinational; upstream must hold the decode slot this cycle.
- o_ex_valid, o_ex_pc, o_ex_rd_addr, o_ex_wren, o_ex_is_load  out  1/PC_W/5/1/1  registered EX control.
- o_ex_rs1_data, o_ex_rs2_data  out  XLEN  registered resolved operands.
- o_ex_rs1_fwd, o_ex_rs2_fwd  out  1  registered; EX must take this operand from the EX/MEM ALU result (producer was in EX).

Behaviour:
- Reset (async, rst_n=0):
  - All registered outputs are 0.
  - o_ex_valid=0.
  - Stall counter (if present) is 0.
- Operand resolution (combinational, per source s in {rs1, rs2}):
  - x0: s_addr==0 gives data 0 and fwd=0; no forwarding match ever occurs on x0.
  - EX match:
    - Condition: o_ex_valid && o_ex_wren && o_ex_rd_addr==s_addr.
    - Data source is the EX producer; fwd=1; data field is don't-care, driven 0.
    - Highest priority.
  - MEM match:
    - Condition: i_mem_wren && i_mem_rd_addr==s_addr.
    - Data = i_mem_data.
  - WB match:
    - Condition: i_wb_wren && i_wb_rd_addr==s_addr.
    - Data = i_wb_data (same-cycle write bypass).
  - Otherwise data = i_s_data.
  - Priority: x0 > EX > MEM > WB > regfile.
- Load-use hazard:
  - Definition: o_load_use_stall = i_id_valid && o_ex_valid && o_ex_is_load && o_ex_wren && o_ex_rd_addr!=0 && (rd matches rs1 or rs2).
  - Next cycle the load is in MEM and its data arrives via i_mem_data, so the stall lasts exactly 1 cycle per dependent pair.
- Register update, priority order per rising edge:
  1. i_flush: bubble (valid=0, wren=0, is_load=0, fwd=0, data=0).
  2. i_stall: hold all EX fields; o_load_use_stall is still driven but no bubble is inserted.
  3. o_load_use_stall: bubble.
  4. Otherwise: load resolved operands and control. Capture valid = i_id_valid; wren/is_load are gated by i_id_valid.
- Latency: 1 cycle from decode inputs to EX outputs.
- Simultaneous flush and load-use stall: flush wins; the stall output is still asserted, and upstream flushes anyway.
- Reset mid-stall: returns to the bubble state immediately with no residual hold.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- Defined:
  - 32-bit counter, output o_stall_cnt (32 bits).
  - Increments on every edge where o_load_use_stall=1, i_stall=0 and i_flush=0.
  - Saturates at 0xFFFFFFFF.
  - Reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Plain read: rs1=5 (regfile 0x11), rs2=6 (0x22), no matches -> next edge o_ex_rs1_data=0x11, rs2=0x22, valid=1, fwd=0.
- WB bypass: i_wb_wren=1, wb_rd=5, wb_data=0xAA, regfile still returns stale 0x11 -> o_ex_rs1_data=0xAA.
- Priority: MEM rd=5 data 0xBB and WB rd=5 data 0xAA -> 0xBB; rs1=0 with WB rd=0 data 0xFF -> data 0.
- Load-use:
  - Stimulus: load to x7 in EX, ID uses rs2=7.
  - Response:
    - o_load_use_stall=1 for one cycle and EX becomes a bubble.
    - Next cycle: stall=0, with MEM rd=7 data 0x1234 -> o_ex_rs2_data=0x1234.
    - Counter=1 when the macro is defined.
- EX forward: non-load to x3 in EX, ID rs1=3 -> no stall; next edge o_ex_rs1_fwd=1.
- Control:
  - i_stall held 3 cycles -> EX outputs unchanged.
  - i_flush with i_stall -> bubble.
  - rst_n low mid-operation -> all outputs 0 asynchronously.
